// File: rtl/sys_bus_pkg.sv
// Shared types and sizing helpers for the round-robin system bus.
package sys_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ERR} bus_state_e;

  localparam int TmoCntW = 16;

  // Index width for an n-entry select, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins, pointer
// moves one past the winner on every grant.
module rr_arbiter
  import sys_bus_pkg::*;
#(
  parameter int N = 2,
  localparam int IdxW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  logic [IdxW-1:0] ptr_q;

  always_comb begin
    int h;
    h     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        h = (int'(ptr_q) + i) % N;
        if (!valid && req[h]) begin
          valid  = 1'b1;
          idx    = IdxW'(h);
          gnt[h] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr_q <= '0;
    else if (valid) ptr_q <= (idx == IdxW'(N - 1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/sys_bus_rr.sv
// Host-to-device interconnect: round-robin arbitration, address decode with
// unmapped-error response, and a per-transaction response timeout.
module sys_bus_rr
  import sys_bus_pkg::*;
#(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 8,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic [NrDevices-1:0]                   device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]                   device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]                   device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]                   device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask_i,
  output logic                                   busy_o,
  output logic                                   timeout_o
);

  localparam int HostIdxW = idx_w(NrHosts);
  localparam int DevIdxW  = idx_w(NrDevices);
  localparam int BeW      = DataWidth / 8;
  localparam logic [TmoCntW-1:0] TmoLast =
    TmoCntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  bus_state_e           state_q, state_d;
  logic [HostIdxW-1:0]  host_q, arb_idx;
  logic [DevIdxW-1:0]   dev_q, hit_idx;
  logic [TmoCntW-1:0]   cnt_q, cnt_d;
  logic [NrHosts-1:0]   arb_gnt;
  logic                 arb_en, arb_valid, hit, tmo;
  logic [AddressWidth-1:0] sel_addr;
  logic                 sel_we;
  logic [BeW-1:0]       sel_be;
  logic [DataWidth-1:0] sel_wdata;

  // Gating with RST_N keeps grants and forwarded fields at zero during reset.
  assign arb_en = (state_q == IDLE) && RST_N;

  rr_arbiter #(.N(NrHosts)) u_arb (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (arb_en),
    .req   (host_req_i),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    if (arb_valid) begin
      sel_addr  = host_addr_i[arb_idx];
      sel_we    = host_we_i[arb_idx];
      sel_be    = host_be_i[arb_idx];
      sel_wdata = host_wdata_i[arb_idx];
    end
  end

  assign device_addr_o  = {NrDevices{sel_addr}};
  assign device_we_o    = {NrDevices{sel_we}};
  assign device_be_o    = {NrDevices{sel_be}};
  assign device_wdata_o = {NrDevices{sel_wdata}};

  // Scan downward so the lowest matching region is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((sel_addr & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d]) begin
        hit     = 1'b1;
        hit_idx = DevIdxW'(d);
      end
    end
  end

  assign tmo    = (TimeoutCycles != 0) && (cnt_q == TmoLast);
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    host_gnt_o    = arb_gnt;
    device_req_o  = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    timeout_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          if (hit) begin
            device_req_o[hit_idx] = 1'b1;
            state_d               = WAIT;
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        if (device_rvalid_i[dev_q]) begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q]    = device_err_i[dev_q];
          host_rdata_o[host_q]  = device_rdata_i[dev_q];
          state_d               = IDLE;
        end else if (tmo) begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q]    = 1'b1;
          timeout_o             = 1'b1;
          state_d               = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        host_rvalid_o[host_q] = 1'b1;
        host_err_o[host_q]    = 1'b1;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      host_q  <= '0;
      dev_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (arb_valid) begin
        host_q <= arb_idx;
        dev_q  <= hit_idx;
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_rr.sv
// Cycle-level bench: directed scenarios then random traffic, all outputs
// compared each cycle against a transaction-level model of the bus.
module tb_sys_bus_rr;
  localparam int NH = 2, ND = 8, DW = 32, AW = 32, TO = 4;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [NH-1:0]          host_req_i, host_gnt_o, host_we_i, host_rvalid_o, host_err_o;
  logic [NH-1:0][AW-1:0]  host_addr_i;
  logic [NH-1:0][DW/8-1:0] host_be_i;
  logic [NH-1:0][DW-1:0]  host_wdata_i, host_rdata_o;
  logic [ND-1:0]          device_req_o, device_we_o, device_rvalid_i, device_err_i;
  logic [ND-1:0][AW-1:0]  device_addr_o, cfg_base, cfg_mask;
  logic [ND-1:0][DW/8-1:0] device_be_o;
  logic [ND-1:0][DW-1:0]  device_wdata_o, device_rdata_i;
  logic                   busy_o, timeout_o;

  sys_bus_rr #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW),
               .TimeoutCycles(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i), .cfg_device_addr_base_i(cfg_base),
    .cfg_device_addr_mask_i(cfg_mask), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Transaction-level model: is a transaction open, who owns it, where it went,
  // and the cycle it was granted in.
  bit m_busy;
  int m_host, m_dev, m_gcyc, m_rr, cyc;
  logic [NH-1:0] obs_gnt, obs_rv, obs_err;
  logic [NH-1:0][DW-1:0] obs_rd;
  logic [ND-1:0] obs_dreq;
  logic obs_busy, obs_to;

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++)
      if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    return -1;
  endfunction

  task automatic tick();
    logic [NH-1:0] e_gnt, e_rv, e_err;
    logic [NH-1:0][DW-1:0] e_rd;
    logic [ND-1:0] e_dreq;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic e_busy, e_to;
    int g, d;
    @(negedge CLK);
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0; e_dreq = '0;
    e_addr = '0; e_wd = '0; e_busy = 1'b0; e_to = 1'b0; g = -1; d = -1;
    if (RST_N) begin
      e_busy = m_busy;
      if (!m_busy) begin
        for (int i = 0; i < NH; i++)
          if (g < 0 && host_req_i[(m_rr + i) % NH]) g = (m_rr + i) % NH;
        if (g >= 0) begin
          e_gnt[g] = 1'b1;
          e_addr   = host_addr_i[g];
          e_wd     = host_wdata_i[g];
          d        = decode(host_addr_i[g]);
          if (d >= 0) e_dreq[d] = 1'b1;
        end
      end else if (m_dev < 0) begin
        e_rv[m_host] = 1'b1; e_err[m_host] = 1'b1;
      end else if (device_rvalid_i[m_dev]) begin
        e_rv[m_host]  = 1'b1;
        e_err[m_host] = device_err_i[m_dev];
        e_rd[m_host]  = device_rdata_i[m_dev];
      end else if (cyc - m_gcyc == TO) begin
        e_rv[m_host] = 1'b1; e_err[m_host] = 1'b1; e_to = 1'b1;
      end
    end
    chk("gnt", 64'(host_gnt_o), 64'(e_gnt));
    chk("rvalid", 64'(host_rvalid_o), 64'(e_rv));
    chk("err", 64'(host_err_o), 64'(e_err));
    chk("rdata", 64'(host_rdata_o), 64'(e_rd));
    chk("dev_req", 64'(device_req_o), 64'(e_dreq));
    chk("busy", 64'(busy_o), 64'(e_busy));
    chk("timeout", 64'(timeout_o), 64'(e_to));
    chk("dev_addr0", 64'(device_addr_o[0]), 64'(e_addr));
    chk("dev_addr7", 64'(device_addr_o[ND-1]), 64'(e_addr));
    chk("dev_wdata3", 64'(device_wdata_o[3]), 64'(e_wd));
    obs_gnt = host_gnt_o; obs_rv = host_rvalid_o; obs_err = host_err_o;
    obs_rd = host_rdata_o; obs_dreq = device_req_o; obs_busy = busy_o; obs_to = timeout_o;
    if (!RST_N) begin
      m_busy = 1'b0; m_rr = 0;
    end else if (!m_busy && g >= 0) begin
      m_busy = 1'b1; m_host = g; m_dev = d; m_gcyc = cyc; m_rr = (g + 1) % NH;
    end else if (m_busy && e_rv != '0) begin
      m_busy = 1'b0;
    end
    cyc++;
    @(posedge CLK); #1;
  endtask

  task automatic quiet();
    host_req_i = '0; device_rvalid_i = '0; device_err_i = '0;
  endtask

  int order[$];
  logic [AW-1:0] atab [7];

  initial begin
    atab = '{32'h0000_0010, 32'h1000_0020, 32'h8000_3000, 32'h8000_F000,
             32'h9000_0000, 32'h4000_0000, 32'h0000_0000};
    for (int d = 0; d < ND; d++) begin cfg_base[d] = '1; cfg_mask[d] = '0; end
    cfg_base[0] = 32'h0000_0000; cfg_mask[0] = 32'hFFFF_0000;
    cfg_base[1] = 32'h1000_0000; cfg_mask[1] = 32'hF000_0000;
    cfg_base[2] = 32'h8000_3000; cfg_mask[2] = 32'hFFFF_F000;
    cfg_base[5] = 32'h8000_0000; cfg_mask[5] = 32'hF000_0000;
    cfg_base[6] = 32'h4000_0000; cfg_mask[6] = 32'hF000_0000;
    host_addr_i = '0; host_we_i = '0; host_be_i = '0; host_wdata_i = '0;
    device_rdata_i = '0; quiet();
    m_busy = 1'b0; m_rr = 0; m_host = 0; m_dev = 0; m_gcyc = 0; cyc = 0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK); #1;
    tick();
    RST_N = 1'b1;

    // host0 read from region 0, one-cycle response
    host_req_i[0] = 1'b1; host_addr_i[0] = 32'h10; host_be_i[0] = 4'hF;
    tick();
    chk("t1_gnt", 64'(obs_gnt), 64'h1);
    chk("t1_dreq", 64'(obs_dreq), 64'h1);
    quiet(); device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'hDEAD_BEEF;
    tick();
    chk("t1_rdata", 64'(obs_rd[0]), 64'hDEAD_BEEF);
    chk("t1_err", 64'(obs_err), 64'h0);

    // host1 unmapped -> error response
    quiet(); host_req_i[1] = 1'b1; host_addr_i[1] = 32'h9000_0000;
    tick();
    chk("t3_dreq", 64'(obs_dreq), 64'h0);
    quiet();
    tick();
    chk("t3_rv", 64'(obs_rv), 64'h2);
    chk("t3_err", 64'(obs_err), 64'h2);

    // both hosts request continuously, device 0 always ready
    host_req_i = '1; host_addr_i[0] = 32'h100; host_addr_i[1] = 32'h200;
    device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int h = 0; h < NH; h++) if (obs_gnt[h]) order.push_back(h);
    end
    chk("rr_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("rr_order", 64'(order[i]), 64'(i % 2));

    // overlapping regions: lowest index wins
    quiet(); host_req_i[0] = 1'b1; host_addr_i[0] = 32'h8000_3000;
    tick();
    chk("ovl_dreq", 64'(obs_dreq), 64'h04);
    quiet(); device_rvalid_i[2] = 1'b1; device_err_i[2] = 1'b1;
    device_rdata_i[2] = 32'hCAFE_0002;
    tick();
    chk("ovl_err", 64'(obs_err), 64'h1);

    // silent device -> timeout 4 cycles after grant, stray rvalid ignored
    quiet(); host_req_i[1] = 1'b1; host_addr_i[1] = 32'h4000_0000;
    tick();
    quiet();
    for (int i = 0; i < TO; i++) tick();
    chk("tmo_pulse", 64'(obs_to), 64'h1);
    chk("tmo_rv", 64'(obs_rv), 64'h2);
    device_rvalid_i[6] = 1'b1;
    tick();
    chk("tmo_busy", 64'(obs_busy), 64'h0);
    chk("tmo_stray", 64'(obs_rv), 64'h0);

    // reset during WAIT
    quiet(); host_req_i[1] = 1'b1; host_addr_i[1] = 32'h300;
    tick();
    RST_N = 1'b0; device_rvalid_i[0] = 1'b1;
    tick();
    chk("rst_out", 64'({obs_gnt, obs_rv, obs_dreq, obs_busy}), 64'h0);
    RST_N = 1'b1; quiet(); host_req_i = '1; host_addr_i[0] = 32'h400;
    tick();
    chk("rst_first", 64'(obs_gnt), 64'h1);
    chk("rst_norv", 64'(obs_rv), 64'h0);
    quiet(); device_rvalid_i[0] = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      for (int h = 0; h < NH; h++) begin
        host_req_i[h]   = $urandom_range(1, 0) == 1;
        host_addr_i[h]  = atab[$urandom_range(6, 0)];
        if ($urandom_range(7, 0) == 0) host_addr_i[h] = $urandom;
        host_we_i[h]    = $urandom_range(1, 0) == 1;
        host_be_i[h]    = 4'($urandom);
        host_wdata_i[h] = $urandom;
      end
      for (int d = 0; d < ND; d++) begin
        device_rvalid_i[d] = $urandom_range(9, 0) < 3;
        device_err_i[d]    = $urandom_range(7, 0) == 0;
        device_rdata_i[d]  = $urandom;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_bus_rr.md
Name: sys_bus_rr

Overview:
Parametrised successor to the system bus interconnect. It connects NrHosts request/grant/rvalid hosts (core data port, debug SBA, future DMA) to NrDevices memory-mapped devices. It adds a fair round-robin arbiter, decoding of unmapped addresses to an error response, and a per-transaction response timeout. It sits between the hosts and the RAM and peripherals in the demo system top and allows one transaction in flight.

Parameters:
NrHosts, 2, number of host ports (1..8)
NrDevices, 8, number of device ports (1..16)
DataWidth, 32, data bus width (multiple of 8)
AddressWidth, 32, address width
TimeoutCycles, 255, cycles in WAIT before an error response is forced; 0 disables the timeout

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
host_req_i  in  [NrHosts] x 1  host request
host_gnt_o  out  [NrHosts] x 1  grant, combinational, one-hot or zero
host_addr_i  in  [NrHosts] x AddressWidth  byte address
host_we_i  in  [NrHosts] x 1  write enable
host_be_i  in  [NrHosts] x DataWidth/8  byte enables
host_wdata_i  in  [NrHosts] x DataWidth  write data
host_rvalid_o  out  [NrHosts] x 1  response valid, one cycle
host_rdata_o  out  [NrHosts] x DataWidth  read data
host_err_o  out  [NrHosts] x 1  error, qualified by rvalid
device_req_o  out  [NrDevices] x 1  device request, one cycle
device_addr_o  out  [NrDevices] x AddressWidth  forwarded address
device_we_o  out  [NrDevices] x 1  forwarded write enable
device_be_o  out  [NrDevices] x DataWidth/8  forwarded byte enables
device_wdata_o  out  [NrDevices] x DataWidth  forwarded write data
device_rvalid_i  in  [NrDevices] x 1  device response valid (reads and writes)
device_rdata_i  in  [NrDevices] x DataWidth  device read data
device_err_i  in  [NrDevices] x 1  device error
cfg_device_addr_base_i  in  [NrDevices] x AddressWidth  region base
cfg_device_addr_mask_i  in  [NrDevices] x AddressWidth  region mask
busy_o  out  1  transaction in flight (state != IDLE)
timeout_o  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Reset: state=IDLE, rr_ptr=0, timeout counter=0, latched host/device indices=0. All gnt, rvalid, err, device_req, busy_o and timeout_o are 0. All rdata outputs are 0.
- Arbitration happens only in IDLE. The granted host is the first requesting host found searching from rr_ptr upward, wrapping modulo NrHosts. host_gnt_o is asserted in the same cycle as the request. On a grant, rr_ptr <= granted+1 mod NrHosts.
- Decode: device d hits when (addr & mask[d]) == base[d]. If several devices hit, the lowest index wins.
- Grant with a hit: device_req_o[d]=1 in the grant cycle only. addr/we/be/wdata are driven combinationally from the granted host. Host and device indices are latched and the state goes to WAIT.
- Grant with no hit: no device_req; state goes to ERR.
- ERR: lasts one cycle. host_rvalid_o[h]=1, host_err_o[h]=1, rdata=0. Returns to IDLE.
- WAIT: each cycle, only device_rvalid_i of the latched device is sampled.
  - On rvalid: host_rvalid_o[h]=1 in the same cycle, with rdata/err passed through combinationally; return to IDLE.
  - Otherwise the counter increments. When counter==TimeoutCycles-1 and rvalid is still absent: rvalid=1, err=1, rdata=0, timeout_o=1; return to IDLE.
  - When TimeoutCycles is 0, WAIT never times out.
- Throughput: no grants while busy. The minimum occupancy is 2 cycles per transaction (grant, then the response cycle at the earliest).
- A device rvalid arriving in IDLE, or from a non-latched device, is ignored. A late response from a timed-out device is therefore dropped unless that device is targeted again. This is a known limitation of the block.
- Simultaneous events: a new request in the response cycle is not granted until the next cycle, when the state is IDLE.
- Reset mid-transaction: the state returns to IDLE immediately and no response is issued.
- Device outputs of non-selected devices: addr, we, be and wdata are driven from the granted host to all devices; only req is qualified per device.

Decomposition:
- Package sys_bus_pkg holds:
  - the state enum bus_state_e {IDLE, WAIT, ERR};
  - index widths: HostIdxW=$clog2(NrHosts) (minimum 1), DevIdxW=$clog2(NrDevices) (minimum 1);
  - the timeout counter width, fixed at 16 bits.
- Sub-module rr_arbiter (param N) contains the request vector, rr_ptr register, update enable, one-hot grant and granted index.

Test Plan:
- Host0 reads 0x00000010 while RAM is region 0 (base 0, mask 0xFFFF0000) and returns 0xDEADBEEF one cycle later -> gnt[0] in cycle 0, device_req[0] in cycle 0, rvalid[0] with rdata 0xDEADBEEF in cycle 1, err=0.
- Both hosts request continuously with rr_ptr=0 -> grant order 0,1,0,1; each gets a response and no host is granted twice in a row.
- Host1 reads 0x90000000 (no region hit) -> no device_req, rvalid[1]=1 and err[1]=1 with rdata 0 one cycle after the grant.
- With TimeoutCycles=4, a device never responds -> rvalid+err and timeout_o pulse exactly 4 cycles after the grant, busy_o drops the next cycle, and a later stray device rvalid is ignored.
- Regions 2 and 5 both match 0x80003000 -> only device_req[2] is asserted.
- RST_N is asserted during WAIT -> all outputs are 0 immediately, no rvalid is issued after reset release, and the first post-reset grant goes to host0.
